// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Purpose:
//   Binary counter with a registered Gray-coded copy of the count. The Gray
//   output is built from the next binary value, so gr and bin update on the
//   same edge and gr always equals bin ^ (bin >> 1) with no relative skew.
//   Under en-only stepping exactly one bit of gr changes per step, including
//   on wrap-around. This is the property the downstream Gray-to-binary stage
//   relies on.
//
// Configuration:
//   GRAY_CNT_UPDN_EN - when defined, adds the up_dn port (1 = up, 0 = down),
//                      and tc flags the last value in the current direction.
//                      When undefined, the counter counts up only and tc
//                      flags the all-ones value.
//
// Parameters:
//   WIDTH   counter width in bits (legal range 2..16)
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset, clears all state
//   en      in   advance the count by one step
//   load    in   synchronous load strobe (has priority over en)
//   ld_val  in   binary value captured on load
//   up_dn   in   count direction (only with GRAY_CNT_UPDN_EN)
//   gr      out  registered Gray-coded count
//   bin     out  registered binary count, aligned with gr
//   tc      out  registered terminal-count flag
//   chg     out  one-cycle pulse when gr changed on the last edge
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
`ifdef GRAY_CNT_UPDN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] gr,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             chg
);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gr_q, gr_d;
  logic             tc_q, tc_d;
  logic             chg_q, chg_d;
  logic             cnt_up;

`ifdef GRAY_CNT_UPDN_EN
  assign cnt_up = up_dn;
`else
  assign cnt_up = 1'b1;
`endif

  always_comb begin
    b_d  = b_q;
    tc_d = tc_q;

    if (load) begin
      b_d = ld_val;
    end else if (en) begin
      b_d = cnt_up ? (b_q + 1'b1) : (b_q - 1'b1);
    end

    // tc follows the value being registered. It is re-evaluated with the
    // direction in force at that edge, and it holds when nothing moves.
    if (load || en) begin
      tc_d = cnt_up ? (b_d == {WIDTH{1'b1}}) : (b_d == {WIDTH{1'b0}});
    end

    // Gray code is derived from the next binary value, so it lands on the
    // same edge as bin.
    gr_d  = b_d ^ (b_d >> 1);
    chg_d = (gr_d != gr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q   <= '0;
      gr_q  <= '0;
      tc_q  <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      b_q   <= b_d;
      gr_q  <= gr_d;
      tc_q  <= tc_d;
      chg_q <= chg_d;
    end
  end

  assign bin = b_q;
  assign gr  = gr_q;
  assign tc  = tc_q;
  assign chg = chg_q;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] ld_val;
`ifdef GRAY_CNT_UPDN_EN
  logic         up_dn;
`endif
  logic [W-1:0] gr;
  logic [W-1:0] bin;
  logic         tc;
  logic         chg;

  int nvec;
  int nerr;

  // Gray sequence for bin = 0..15, written out by hand.
  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .ld_val (ld_val),
`ifdef GRAY_CNT_UPDN_EN
    .up_dn  (up_dn),
`endif
    .gr     (gr),
    .bin    (bin),
    .tc     (tc),
    .chg    (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int popcnt4(input logic [3:0] v);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) if (v[k]) n++;
    return n;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev_gr;
    logic [3:0] eb;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    ld_val = '0;
`ifdef GRAY_CNT_UPDN_EN
    up_dn = 1'b1;
`endif

    // Reset state
    #3;
    chk("rst_bin", bin, 4'h0);
    chk("rst_gr",  gr,  4'h0);
    chk("rst_tc",  tc,  1'b0);
    chk("rst_chg", chg, 1'b0);

    // Reset overrides load and en across an edge
    en = 1'b1; load = 1'b1; ld_val = 4'b1111;
    step();
    chk("rst_ovr_bin", bin, 4'h0);
    chk("rst_ovr_gr",  gr,  4'h0);
    #3;
    rst = 1'b0;
    load = 1'b0;

    // Up count for 16 steps with wrap, Hamming-distance check
    prev_gr = gr;
    for (int i = 1; i <= 16; i++) begin
      step();
      eb = 4'(i % 16);
      chk($sformatf("up_bin_%0d", i), bin, eb);
      chk($sformatf("up_gr_%0d", i),  gr,  gray_tab[eb]);
      chk($sformatf("up_tc_%0d", i),  tc,  (eb == 4'hF));
      chk($sformatf("up_chg_%0d", i), chg, 1'b1);
      chk($sformatf("up_ham_%0d", i), popcnt4(gr ^ prev_gr), 1);
      prev_gr = gr;
    end

    // Load wins over en in the same cycle
    load = 1'b1; ld_val = 4'b1010; en = 1'b1;
    step();
    chk("ld_bin", bin, 4'b1010);
    chk("ld_gr",  gr,  4'b1111);
    chk("ld_chg", chg, 1'b1);
    chk("ld_tc",  tc,  1'b0);
    load = 1'b0;
    step();
    chk("ld_next_bin", bin, 4'b1011);
    chk("ld_next_gr",  gr,  4'b1110);

    // Terminal count holds while idle
    load = 1'b1; ld_val = 4'b1110; en = 1'b0;
    step();
    chk("tc_pre", tc, 1'b0);
    load = 1'b0; en = 1'b1;
    step();
    chk("tc_bin", bin, 4'b1111);
    chk("tc_set", tc,  1'b1);
    en = 1'b0;
    step();
    chk("tc_hold",     tc,  1'b1);
    chk("tc_hold_chg", chg, 1'b0);

    // Hold at 0101 for 5 cycles, then load of the same value
    load = 1'b1; ld_val = 4'b0101;
    step();
    chk("h_ld_bin", bin, 4'b0101);
    chk("h_ld_gr",  gr,  4'b0111);
    chk("h_ld_chg", chg, 1'b1);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_bin_%0d", i), bin, 4'b0101);
      chk($sformatf("hold_gr_%0d", i),  gr,  4'b0111);
      chk($sformatf("hold_tc_%0d", i),  tc,  1'b0);
      chk($sformatf("hold_chg_%0d", i), chg, 1'b0);
    end
    load = 1'b1; ld_val = 4'b0101;
    step();
    chk("same_ld_bin", bin, 4'b0101);
    chk("same_ld_gr",  gr,  4'b0111);
    chk("same_ld_chg", chg, 1'b0);
    load = 1'b0;

    // Count to 0110, then asynchronous reset between edges
    en = 1'b1;
    step();
    chk("pre_arst_bin", bin, 4'b0110);
    chk("pre_arst_gr",  gr,  4'b0101);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_bin", bin, 4'h0);
    chk("arst_gr",  gr,  4'h0);
    chk("arst_chg", chg, 1'b0);
    chk("arst_tc",  tc,  1'b0);
    #2;
    rst = 1'b0;
    en = 1'b1;
    step();
    chk("post_arst_bin", bin, 4'b0001);
    chk("post_arst_gr",  gr,  4'b0001);

`ifdef GRAY_CNT_UPDN_EN
    // Down count from 0000 through wrap back to 0000
    en = 1'b0; load = 1'b1; ld_val = 4'b0000;
    step();
    chk("dn_start_bin", bin, 4'b0000);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    step();
    chk("dn_wrap_bin", bin, 4'b1111);
    chk("dn_wrap_gr",  gr,  4'b1000);
    chk("dn_wrap_tc",  tc,  1'b0);
    prev_gr = gr;
    for (int i = 14; i >= 0; i--) begin
      step();
      eb = 4'(i);
      chk($sformatf("dn_bin_%0d", i), bin, eb);
      chk($sformatf("dn_gr_%0d", i),  gr,  gray_tab[eb]);
      chk($sformatf("dn_tc_%0d", i),  tc,  (eb == 4'h0));
      chk($sformatf("dn_ham_%0d", i), popcnt4(gr ^ prev_gr), 1);
      prev_gr = gr;
    end
    // Direction change re-evaluates tc on the next step
    up_dn = 1'b1;
    step();
    chk("dir_bin", bin, 4'b0001);
    chk("dir_tc",  tc,  1'b0);
`endif

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
